// File: rtl/sram_i_stream_reader_pkg.sv
// Shared constants, FSM state type and address helper for the input-feature
// SRAM stream reader.
package sram_i_stream_reader_pkg;

  localparam int WORD_AMOUNT = 3136;
  localparam int DATA_W      = 145;
  localparam int ADDR_W      = $clog2(WORD_AMOUNT);
  localparam int FIFO_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Next word address, wrapping modulo WORD_AMOUNT so it never leaves the array.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(WORD_AMOUNT - 1)) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/sram_i_stream_reader_if.sv
// Valid/ready stream carrying SRAM words towards the convolution datapath.
interface sram_i_stream_reader_if;

  logic                                      out_valid;
  logic                                      out_ready;
  logic [sram_i_stream_reader_pkg::DATA_W-1:0] out_data;
  logic                                      out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);

endinterface

// File: rtl/sram_i_stream_reader_skid_fifo.sv
// Small skid FIFO absorbing read returns while the stream is back-pressured.
module stream_skid_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointer and occupancy update; push and pop may coincide.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = ptr_inc(wr_q);
    end
    if (do_pop) rd_d = ptr_inc(rd_q);
    case ({push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers, cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign empty = (count_q == '0);
  assign count = count_q;

  // The upstream credit scheme never lets a push land on a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/sram_i_stream_reader.sv
// Sweeps an SRAM address window one read per cycle and re-times the
// 1-cycle-latency read data into a back-pressurable stream.
module sram_i_stream_reader
  import sram_i_stream_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       length,
  output logic [ADDR_W-1:0]     sram_addr,
  input  logic [DATA_W-1:0]     sram_dout,
  sram_i_stream_reader_if.master strm,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic              done_q, done_d;

  logic [DATA_W:0]   fifo_head;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occ;
  logic              pop;
  logic              can_issue;

  // Read return lands one cycle after the issue; the last tag rides along.
  stream_skid_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .pop   (pop),
    .din   ({inflight_last_q, sram_dout}),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign strm.out_valid = !fifo_empty;
  assign strm.out_data  = fifo_head[DATA_W-1:0];
  assign strm.out_last  = fifo_head[DATA_W];
  assign pop            = !fifo_empty && strm.out_ready;

  // Credit: queued + in-flight words may not exceed the FIFO, except that a
  // same-cycle pop frees the slot the new read will need.
  assign occ       = {1'b0, fifo_count} + (CW+1)'(inflight_q);
  assign can_issue = (occ < (CW+1)'(FIFO_DEPTH)) ||
                     ((occ == (CW+1)'(FIFO_DEPTH)) && pop);

  // Next-state and issue logic for the window sweep.
  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    remaining_d     = remaining_q;
    sram_addr_d     = sram_addr_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    done_d          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d     = ISSUE;
            cur_addr_d  = base_addr;
            remaining_d = length;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (can_issue) begin
          sram_addr_d     = cur_addr_q;
          inflight_d      = 1'b1;
          inflight_last_d = (remaining_q == (ADDR_W+1)'(1));
          cur_addr_d      = next_addr(cur_addr_q);
          remaining_d     = remaining_q - 1'b1;
          if (remaining_q == (ADDR_W+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && strm.out_last && !inflight_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cur_addr_q      <= '0;
      remaining_q     <= '0;
      sram_addr_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cur_addr_q      <= cur_addr_d;
      remaining_q     <= remaining_d;
      sram_addr_q     <= sram_addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  // Address is presented in the issue cycle and held otherwise.
  assign sram_addr = sram_addr_d;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_sram_i_stream_reader.sv
// Scoreboard bench for sram_i_stream_reader with a registered SRAM model.
module tb_sram_i_stream_reader;
  import sram_i_stream_reader_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   length = '0;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dout = '0;
  logic              busy;
  logic              done;

  sram_i_stream_reader_if sif();

  sram_i_stream_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .sram_addr (sram_addr),
    .sram_dout (sram_dout),
    .strm      (sif),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] e;
  logic [DATA_W:0] held;
  logic            stall_prev = 1'b0;
  bit              bp_mode = 1'b0;
  int              pidx = 0;
  int              pat[8] = '{1, 0, 0, 1, 0, 1, 1, 0};

  function automatic logic [DATA_W-1:0] word_of(input int a);
    logic [63:0] a64;
    a64 = 64'(a);
    return {17'(a), a64 * 64'h9E37_79B9_7F4A_7C15, a64 ^ 64'hDEAD_BEEF_0123_4567};
  endfunction

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // SRAM: registered read, one cycle latency.
  always @(posedge clk) sram_dout <= word_of(int'(sram_addr));

  // Downstream ready driver.
  initial begin
    sif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        sif.out_ready = pat[pidx] != 0;
        pidx = (pidx + 1) % 8;
      end else begin
        sif.out_ready = 1'b1;
      end
    end
  end

  // Monitor: payload stability during stalls and in-order scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 160'(sif.out_valid), 160'(1));
        check("stall_payload", 160'({sif.out_last, sif.out_data}), 160'(held));
      end
      if (sif.out_valid && sif.out_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 160'(sif.out_valid), 160'(0));
        end else begin
          e = exp_q.pop_front();
          check("beat", 160'({sif.out_last, sif.out_data}), 160'(e));
        end
      end
      stall_prev = sif.out_valid && !sif.out_ready;
      held = {sif.out_last, sif.out_data};
    end
  end

  task automatic push_window(input int base, input int len);
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == len - 1), word_of((base + i) % WORD_AMOUNT)});
  endtask

  // Start a window and wait for done; exp_lat < 0 skips the latency check.
  task automatic run(input string nm, input int base, input int len, input int exp_lat,
                     input int inj, input int inj_base);
    int n;
    bit got;
    push_window(base, len);
    @(negedge clk);
    start = 1'b1;
    base_addr = ADDR_W'(base);
    length = (ADDR_W+1)'(len);
    n = 0;
    got = 1'b0;
    while (n < len * 3 + 60) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        check({nm, "_busy"}, 160'(busy), 160'(len != 0));
        if (len == 0) check({nm, "_no_valid"}, 160'(sif.out_valid), 160'(0));
      end
      if (inj > 0 && n == inj) begin
        start = 1'b1;
        base_addr = ADDR_W'(inj_base);
        length = (ADDR_W+1)'(5);
      end else if (inj > 0 && n == inj + 1) begin
        start = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check({nm, "_done_seen"}, 160'(got), 160'(1));
    if (exp_lat >= 0) check({nm, "_latency"}, 160'(n), 160'(exp_lat));
    check({nm, "_all_beats"}, 160'(exp_q.size()), 160'(0));
    @(negedge clk);
    check({nm, "_idle_busy"}, 160'(busy), 160'(0));
    check({nm, "_done_pulse"}, 160'(done), 160'(0));
  endtask

  initial begin
    int b0;
    int guard;
    repeat (3) @(negedge clk);
    check("rst_valid", 160'(sif.out_valid), 160'(0));
    check("rst_data", 160'(sif.out_data), 160'(0));
    check("rst_last", 160'(sif.out_last), 160'(0));
    check("rst_busy", 160'(busy), 160'(0));
    check("rst_done", 160'(done), 160'(0));
    check("rst_addr", 160'(sram_addr), 160'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run("full", 0, WORD_AMOUNT, WORD_AMOUNT + 3, 0, 0);
    run("wrap", 3130, 10, 13, 0, 0);
    bp_mode = 1'b1;
    pidx = 0;
    run("bp", 77, 8, -1, 0, 0);
    bp_mode = 1'b0;
    repeat (2) @(negedge clk);
    run("zero", 5, 0, 1, 0, 0);
    run("busy_start", 100, 12, 15, 4, 500);

    // Reset in the middle of a 20-word window.
    push_window(200, 20);
    b0 = beats;
    @(negedge clk);
    start = 1'b1;
    base_addr = ADDR_W'(200);
    length = (ADDR_W+1)'(20);
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (beats < b0 + 5 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("midrst_5beats", 160'(beats - b0), 160'(5));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 160'(sif.out_valid), 160'(0));
    check("midrst_data", 160'(sif.out_data), 160'(0));
    check("midrst_last", 160'(sif.out_last), 160'(0));
    check("midrst_busy", 160'(busy), 160'(0));
    check("midrst_done", 160'(done), 160'(0));
    check("midrst_addr", 160'(sram_addr), 160'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("postrst_quiet", 160'(sif.out_valid), 160'(0));
    run("postrst", 40, 6, 9, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
